// File: rtl/iomem_arbiter_if.sv
// rtl/iomem_arbiter_if.sv - 32-bit peripheral bus: valid/ready handshake with byte strobes.
interface iomem_arbiter_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_arbiter.sv
// rtl/iomem_arbiter.sv - two-master round-robin arbiter for one peripheral bus port, with per-transaction timeout.
module iomem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    iomem_arbiter_if.slave   m0,
    iomem_arbiter_if.slave   m1,
    iomem_arbiter_if.master  s,
    output logic             timeout,
    output logic [7:0]       err_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          s_valid_q, s_valid_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          m0_ready_q, m0_ready_d;
    logic          m1_ready_q, m1_ready_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    err_q, err_d;
    logic          sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            timer_q    <= '0;
            s_valid_q  <= 1'b0;
            wstrb_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
            s_valid_q  <= s_valid_d;
            wstrb_q    <= wstrb_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        timer_d    = timer_q;
        s_valid_d  = s_valid_q;
        wstrb_d    = wstrb_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        timeout_d  = 1'b0;
        err_d      = err_q;
        sel        = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    // On a tie the master that was not served last wins.
                    sel       = (m0.valid && m1.valid) ? ~last_q : m1.valid;
                    grant_d   = sel;
                    wstrb_d   = sel ? m1.wstrb : m0.wstrb;
                    addr_d    = sel ? m1.addr  : m0.addr;
                    wdata_d   = sel ? m1.wdata : m0.wdata;
                    timer_d   = '0;
                    s_valid_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (s.ready || timer_q == TIMER_LAST) begin
                    if (s.ready) begin
                        rdata_d = s.rdata;
                    end else begin
                        rdata_d   = 32'hFFFF_FFFF;
                        timeout_d = 1'b1;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                    s_valid_d  = 1'b0;
                    m0_ready_d = ~grant_q;
                    m1_ready_d = grant_q;
                    state_d    = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s.valid   = s_valid_q;
    assign s.wstrb   = wstrb_q;
    assign s.addr    = addr_q;
    assign s.wdata   = wdata_q;
    assign m0.ready  = m0_ready_q;
    assign m1.ready  = m1_ready_q;
    assign m0.rdata  = rdata_q;
    assign m1.rdata  = rdata_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_iomem_arbiter.sv
// tb/tb_iomem_arbiter.sv - transaction-level self-checking bench for iomem_arbiter.
module tb_iomem_arbiter;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       timeout;
    logic [7:0] err_count;

    iomem_arbiter_if m0_if();
    iomem_arbiter_if m1_if();
    iomem_arbiter_if s_if();

    iomem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .timeout   (timeout),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: last served master, timeout tally, and each master's pending request.
    int          last_g = 1;
    int          err_m = 0;
    logic        v  [2];
    logic [3:0]  ws [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic drive();
        m0_if.valid = v[0]; m0_if.wstrb = ws[0]; m0_if.addr = ad[0]; m0_if.wdata = wd[0];
        m1_if.valid = v[1]; m1_if.wstrb = ws[1]; m1_if.addr = ad[1]; m1_if.wdata = wd[1];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        v[m] = 1'b1; ws[m] = w; ad[m] = a; wd[m] = d;
        drive();
    endtask

    function automatic logic rdy(input int m);
        return (m == 1) ? m1_if.ready : m0_if.ready;
    endfunction

    function automatic logic [31:0] rdt(input int m);
        return (m == 1) ? m1_if.rdata : m0_if.rdata;
    endfunction

    task automatic chk_quiet(input string name);
        chk1({name, ".s_valid"}, s_if.valid, 1'b0);
        chk1({name, ".m0_ready"}, m0_if.ready, 1'b0);
        chk1({name, ".m1_ready"}, m1_if.ready, 1'b0);
        chk1({name, ".timeout"}, timeout, 1'b0);
        chk({name, ".err_count"}, 32'(err_count), err_m);
    endtask

    // Called in an IDLE cycle with at least one request driven; the peripheral answers in
    // BUSY cycle 'ans' (answers later than T mean it never answers in time).
    task automatic run_txn(input int ans, input logic [31:0] rd,
                           output int g_dut, output int lat, output logic [31:0] rd_dut);
        int   g;
        int   len;
        logic to;
        g   = (v[0] && v[1]) ? 1 - last_g : (v[1] ? 1 : 0);
        to  = (ans > T);
        len = to ? T : ans;
        for (int j = 1; j <= len; j++) begin
            step();
            s_if.ready = (j == ans);
            s_if.rdata = (j == ans) ? rd : $urandom;
            chk1("busy.s_valid", s_if.valid, 1'b1);
            chk("busy.s_addr", s_if.addr, ad[g]);
            chk("busy.s_wstrb", 32'(s_if.wstrb), 32'(ws[g]));
            chk("busy.s_wdata", s_if.wdata, wd[g]);
            chk1("busy.m0_ready", m0_if.ready, 1'b0);
            chk1("busy.m1_ready", m1_if.ready, 1'b0);
            chk1("busy.timeout", timeout, 1'b0);
            chk("busy.err_count", 32'(err_count), err_m);
        end
        step();
        if (to && err_m < 255) err_m++;
        s_if.ready = 1'($urandom_range(0, 1));
        s_if.rdata = $urandom;
        chk1("done.s_valid", s_if.valid, 1'b0);
        chk1("done.ready_granted", rdy(g), 1'b1);
        chk1("done.ready_other", rdy(1 - g), 1'b0);
        chk("done.rdata", rdt(g), to ? 32'hFFFF_FFFF : rd);
        chk1("done.timeout", timeout, to);
        chk("done.err_count", 32'(err_count), err_m);
        g_dut  = m1_if.ready ? 1 : (m0_if.ready ? 0 : -1);
        lat    = (m0_if.ready || m1_if.ready) ? len + 1 : -1;
        rd_dut = rdt(g);
        v[g]   = 1'b0;
        drive();
        last_g = g;
        step();
        s_if.ready = 1'($urandom_range(0, 1));
        chk_quiet("idle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int          g;
        int          lat;
        logic [31:0] rd;
        int          order [4];

        for (int m = 0; m < 2; m++) begin
            v[m] = 1'b0; ws[m] = '0; ad[m] = '0; wd[m] = '0;
        end
        drive();
        s_if.ready = 1'b0;
        s_if.rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset.s_addr", s_if.addr, 32'h0);
        chk("reset.s_wdata", s_if.wdata, 32'h0);
        chk("reset.s_wstrb", 32'(s_if.wstrb), 32'h0);
        chk("reset.rdata", m0_if.rdata, 32'h0);
        reset = 1'b0;

        // Simultaneous requests out of reset: master 0 first, then the pending master 1.
        set_req(0, 4'b1111, 32'h0300_0004, 32'h0000_00A5);
        set_req(1, 4'b0000, 32'h0300_0008, 32'h0);
        run_txn(1, 32'h0000_0011, g, lat, rd);
        chk("tie.first_grant", g, 0);
        run_txn(2, 32'h0000_0022, g, lat, rd);
        chk("tie.second_grant", g, 1);
        chk("tie.second_rdata", rd, 32'h0000_0022);

        // Both held continuously.
        for (int n = 0; n < 4; n++) begin
            if (!v[0]) set_req(0, 4'($urandom), $urandom, $urandom);
            if (!v[1]) set_req(1, 4'($urandom), $urandom, $urandom);
            run_txn(1 + n, $urandom, g, lat, rd);
            order[n] = g;
        end
        v[0] = 1'b0; v[1] = 1'b0; drive();
        chk("alternate.0", order[0], 0);
        chk("alternate.1", order[1], 1);
        chk("alternate.2", order[2], 0);
        chk("alternate.3", order[3], 1);

        // Single read from master 0.
        set_req(0, 4'b0000, 32'h0300_0000, 32'h0);
        run_txn(2, 32'h0000_0003, g, lat, rd);
        chk("read.grant", g, 0);
        chk("read.rdata", rd, 32'h0000_0003);
        chk("read.edges_to_ready", lat, 3);

        // Write strobe passthrough from master 1.
        set_req(1, 4'b0101, 32'h0300_0010, 32'h1122_3344);
        run_txn(5, 32'h0, g, lat, rd);
        chk("wstrb.grant", g, 1);

        // Timeout with no peripheral answer.
        set_req(0, 4'b0000, 32'h0400_0000, 32'h0);
        run_txn(T + 1, 32'h0, g, lat, rd);
        chk("timeout.rdata", rd, 32'hFFFF_FFFF);
        chk("timeout.err_count", 32'(err_count), 32'd1);
        chk("timeout.edges_to_ready", lat, 9);

        // Answer on the very cycle the timer would expire.
        set_req(0, 4'b0000, 32'h0400_0004, 32'h0);
        run_txn(T, 32'h0000_1234, g, lat, rd);
        chk("edge.rdata", rd, 32'h0000_1234);
        chk("edge.err_count", 32'(err_count), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            if (!v[0] && $urandom_range(0, 2) != 0) set_req(0, 4'($urandom), $urandom, $urandom);
            if (!v[1] && $urandom_range(0, 2) != 0) set_req(1, 4'($urandom), $urandom, $urandom);
            if (!v[0] && !v[1]) begin
                step();
                s_if.ready = 1'($urandom_range(0, 1));
                chk_quiet("gap");
            end else begin
                run_txn($urandom_range(1, T + 2), $urandom, g, lat, rd);
            end
        end
        while (v[0] || v[1]) run_txn(1, $urandom, g, lat, rd);

        // Reset in the middle of a transaction.
        if (err_m == 0) begin
            set_req(1, 4'b0000, 32'h0500_0000, 32'h0);
            run_txn(T + 1, 32'h0, g, lat, rd);
        end
        set_req(0, 4'b0011, 32'h0600_0000, 32'hDEAD_BEEF);
        step();
        s_if.ready = 1'b0;
        chk1("midreset.busy", s_if.valid, 1'b1);
        step();
        #2;
        reset = 1'b1;
        #1;
        err_m = 0; last_g = 1; v[0] = 1'b0; drive();
        chk_quiet("midreset");
        chk("midreset.s_addr", s_if.addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk_quiet("noreplay.0");
        step();
        chk_quiet("noreplay.1");
        set_req(1, 4'b0000, 32'h0300_0000, 32'h0);
        run_txn(3, 32'hCAFE_0001, g, lat, rd);
        chk("afterreset.grant", g, 1);
        chk("afterreset.rdata", rd, 32'hCAFE_0001);

        // Saturation of the timeout counter.
        for (int n = 0; n < 300; n++) begin
            set_req($urandom_range(0, 1), 4'($urandom), $urandom, $urandom);
            run_txn(T + 1, 32'h0, g, lat, rd);
        end
        chk("saturate.err_count", 32'(err_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
